// File: rtl/neuron_accum_fp.sv
// neuron_accum_fp: single-neuron weighted sum of signed Q8.8 pairs,
// saturated to Q16.16 and converted to IEEE-754 float32.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_x/in_w pair
// input; bias (only when NEURON_BIAS_EN is defined); out_valid/out_ready/
// out_y/out_sat result output.
// Optional macro: NEURON_BIAS_EN adds a Q8.8 bias loaded on the first beat.
module neuron_accum_fp #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_x,
    input  logic [15:0] in_w,
`ifdef NEURON_BIAS_EN
    input  logic [15:0] bias,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_y,
    output logic        out_sat
);

    localparam logic [1:0] S_ACCUM = 2'd0;
    localparam logic [1:0] S_SAT   = 2'd1;
    localparam logic [1:0] S_NORM  = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic [31:0]      mag_q, mag_d;
    logic             sat_q, sat_d;
    logic [31:0]      out_y_q, out_y_d;
    logic             out_sat_q, out_sat_d;
    logic             out_valid_q, out_valid_d;

    logic signed [31:0] prod;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   base;
    logic               over, under;
    logic [31:0]        clamped;
    logic [4:0]         lead;
    logic [4:0]         sh;
    logic [22:0]        mant;
    logic [7:0]         expo;

    assign prod     = $signed(in_x) * $signed(in_w);
    assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};

`ifdef NEURON_BIAS_EN
    // Q8.8 bias moved to Q16.16 and seeded only on the first beat.
    assign base = (cnt_q == 8'd0) ?
                  {{(ACC_W-24){bias[15]}}, bias, 8'h00} : acc_q;
`else
    assign base = (cnt_q == 8'd0) ? '0 : acc_q;
`endif

    // Anything above bit 31 that is not pure sign extension is out of range.
    assign over    = ~acc_q[ACC_W-1] & (|acc_q[ACC_W-2:31]);
    assign under   = acc_q[ACC_W-1] & ~(&acc_q[ACC_W-2:31]);
    assign clamped = over  ? 32'h7FFF_FFFF :
                     under ? 32'h8000_0000 : acc_q[31:0];

    always_comb begin
        lead = '0;
        for (int i = 0; i < 32; i++) begin
            if (mag_q[i]) lead = 5'(i);
        end
    end

    // Leading one shifted to bit 31, fraction taken from bits 30:8.
    assign sh   = 5'd31 - lead;
    assign mant = 23'((mag_q << sh) >> 8);
    assign expo = 8'd111 + {3'b000, lead};

    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_sat   = out_sat_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        mag_d       = mag_q;
        sat_d       = sat_q;
        out_y_d     = out_y_q;
        out_sat_d   = out_sat_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_ACCUM: begin
                if (in_valid) begin
                    acc_d = base + prod_ext;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'(N_TERMS - 1)) state_d = S_SAT;
                end
            end
            S_SAT: begin
                sat_d   = over | under;
                sign_d  = clamped[31];
                mag_d   = clamped[31] ? (~clamped + 32'd1) : clamped;
                state_d = S_NORM;
            end
            S_NORM: begin
                out_y_d     = (mag_q == 32'd0) ? 32'd0 : {sign_q, expo, mant};
                out_sat_d   = sat_q;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            default: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    cnt_d       = '0;
                    state_d     = S_ACCUM;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            sat_q       <= 1'b0;
            out_y_q     <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            sat_q       <= sat_d;
            out_y_q     <= out_y_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_neuron_accum_fp.sv
// tb_neuron_accum_fp: directed table vectors, handshake/reset sequences
// and randomized neurons checked against a real-arithmetic float model.
module tb_neuron_accum_fp;

    localparam int NT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_x = '0;
    logic [15:0] in_w = '0;
`ifdef NEURON_BIAS_EN
    logic [15:0] bias = '0;
`endif
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_y;
    logic        out_sat;

    int n_cmp = 0;
    int n_bad = 0;

    neuron_accum_fp #(.N_TERMS(NT), .ACC_W(40)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_x(in_x),
        .in_w(in_w),
`ifdef NEURON_BIAS_EN
        .bias(bias),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_y(out_y),
        .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        string             name;
        logic [3:0][15:0]  x;
        logic [3:0][15:0]  w;
        logic [31:0]       y;
        logic              sat;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: exact integer sum, clamp, then float encode via reals.
    function automatic logic [32:0] ref_fp(input longint s);
        longint c;
        real    m;
        int     e;
        int     mt;
        logic   sat;
        sat = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        c = (s > 64'sd2147483647) ? 64'sd2147483647 :
            (s < -64'sd2147483648) ? -64'sd2147483648 : s;
        if (c == 0) return {sat, 32'h0};
        m = ((c < 0) ? -c : c) / 65536.0;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        mt = $rtoi((m - 1.0) * 8388608.0);
        return {sat, (c < 0), 8'(e + 127), 23'(mt)};
    endfunction

    task automatic send(input logic [15:0] x, input logic [15:0] w);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_x = x;
        in_w = w;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_x = 16'($urandom);
        in_w = 16'($urandom);
    endtask

    task automatic feed(input logic [3:0][15:0] x, input logic [3:0][15:0] w,
                        input bit stall, output longint sum);
        sum = 0;
`ifdef NEURON_BIAS_EN
        sum = longint'($signed(bias)) * 256;
`endif
        for (int i = 0; i < NT; i++) begin
            if (stall) repeat ($urandom_range(0, 2)) @(negedge clk);
            send(x[i], w[i]);
            sum += longint'($signed(x[i])) * longint'($signed(w[i]));
        end
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic collect(input string nm, input logic [31:0] ey,
                           input logic es, input int dly);
        wait_valid(nm);
        repeat (dly) @(negedge clk);
        chk({nm, "_y"}, out_y, ey);
        chk({nm, "_sat"}, 32'(out_sat), 32'(es));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    logic [3:0][15:0] one4;
    logic [3:0][15:0] rx;
    logic [3:0][15:0] rw;
    longint           sum;
    logic [32:0]      r;

    initial begin
        tbl[0] = '{"unity", {4{16'h0100}}, {4{16'h0100}}, 32'h4080_0000, 1'b0};
        tbl[1] = '{"neg", {16'h0, 16'h0, 16'h0, 16'hFE80},
                   {16'h0, 16'h0, 16'h0, 16'h0200}, 32'hC040_0000, 1'b0};
        tbl[2] = '{"zero", {4{16'h0}}, {4{16'h0}}, 32'h0, 1'b0};
        tbl[3] = '{"sat_pos", {4{16'h7FFF}}, {4{16'h7FFF}}, 32'h46FF_FFFF, 1'b1};
        tbl[4] = '{"sat_neg", {4{16'h8000}}, {4{16'h7FFF}}, 32'hC700_0000, 1'b1};
        tbl[5] = '{"min", {16'h0, 16'h0, 16'h0, 16'h0001},
                   {16'h0, 16'h0, 16'h0, 16'h0001}, 32'h3780_0000, 1'b0};
        one4 = {4{16'h0100}};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_y", out_y, 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);

        for (int i = 0; i < 6; i++) begin
            feed(tbl[i].x, tbl[i].w, 1'b0, sum);
            if (i == 0) begin
                @(negedge clk);
                chk("lat_e0", 32'(out_valid), 32'd0);
                chk("lat_busy", 32'(in_ready), 32'd0);
                @(negedge clk);
                chk("lat_e1", 32'(out_valid), 32'd0);
                @(negedge clk);
                chk("lat_e2", 32'(out_valid), 32'd1);
            end
            collect(tbl[i].name, tbl[i].y, tbl[i].sat, 0);
        end

        // Backpressure: result held, inputs refused even with in_valid high.
        feed(one4, one4, 1'b0, sum);
        wait_valid("bp");
        in_valid = 1'b1;
        in_x = 16'h7FFF;
        in_w = 16'h7FFF;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_y", out_y, 32'h4080_0000);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        chk("bp_release_valid", 32'(out_valid), 32'd0);

        // Mid-run reset discards a partial sum.
        send(16'h0100, 16'h0100);
        send(16'h0100, 16'h0100);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        feed(one4, one4, 1'b0, sum);
        collect("mid_rst", 32'h4080_0000, 1'b0, 0);

        // Reset while an output is pending drops it.
        feed(one4, one4, 1'b0, sum);
        wait_valid("out_rst");
        @(negedge clk);
        out_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("out_rst_valid", 32'(out_valid), 32'd0);
        chk("out_rst_y", out_y, 32'd0);

`ifdef NEURON_BIAS_EN
        bias = 16'h0080;
        feed(one4, one4, 1'b0, sum);
        collect("bias", 32'h4090_0000, 1'b0, 0);
        bias = 16'h0000;
`endif

        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < NT; i++) begin
                if (k % 2 == 0) begin
                    rx[i] = 16'($urandom);
                    rw[i] = 16'($urandom);
                end else begin
                    rx[i] = 16'($urandom_range(0, 1023) - 512);
                    rw[i] = 16'($urandom_range(0, 1023) - 512);
                end
            end
`ifdef NEURON_BIAS_EN
            bias = 16'($urandom);
`endif
            feed(rx, rw, 1'b1, sum);
            r = ref_fp(sum);
            collect("rnd", r[31:0], r[32], int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
